fb_scheduler: RTL and testbench



---
 rtl/fb_sched_pkg.sv | 24 ++
 rtl/fb_wr_fifo.sv | 59 +++++
 rtl/fb_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_fb_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_sched_pkg.sv
// fb_sched_pkg: shared types and constants for the frame-buffer scheduler.
package fb_sched_pkg;

  // Every SRAM access occupies a two-cycle slot; the FSM names both halves.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    RD1  = 3'd2,
    WR0  = 3'd3,
    WR1  = 3'd4
  } fb_sched_state_t;

  // Cycles per memory slot (RDx / WRx pairs).
  localparam int SLOT_LEN = 2;

  // The page-select bit sits directly above the in-page word address.
  localparam int PAGE_BIT = 19;

  // True while the SRAM port is owned by a write slot.
  function automatic logic isWriteSlot(input fb_sched_state_t s);
    return (s == WR0) || (s == WR1);
  endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// fb_wr_fifo: synchronous write FIFO carrying {addr, data} pixel writes.
// Ready is a registered "not full" so the writer sees a clean flop output.
module fb_wr_fifo #(
  parameter int WIDTH = 51,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_empty,
  output logic             o_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [AW:0]      r_count;
  logic             r_ready;
  logic             w_push;
  logic             w_pop;
  logic [AW:0]      w_countNext;

  assign w_push      = i_push && (r_count != C_FULL);
  assign w_pop       = i_pop && (r_count != '0);
  assign w_countNext = r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};

  assign o_head  = r_mem[r_rdPtr];
  assign o_empty = (r_count == '0);
  assign o_ready = r_ready;

  // Storage array: written on push, never reset (pointers define validity).
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= i_din;
    end
  end

  // Pointer/occupancy bookkeeping; ready is precomputed from next occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_ready <= 1'b1;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + AW'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + AW'(1);
      r_count <= w_countNext;
      r_ready <= (w_countNext != C_FULL);
    end
  end

endmodule

// File: rtl/fb_scheduler.sv
// fb_scheduler: shares the single SRAM port between display reads (priority)
// and buffered pixel writes, and owns double-buffer page selection.
// Optional feature: define FB_STARVE_GUARD_EN to force one write slot after
// STARVE_MAX consecutive read slots taken while writes are waiting.
module fb_scheduler
  import fb_sched_pkg::*;
#(
  parameter int ADDR_W     = PAGE_BIT,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int STARVE_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  output logic              disp_overrun,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              swap_req,
  output logic              swap_ack,
  input  logic              vblank,
  output logic              front_page,
  output logic [ADDR_W:0]   mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_en,
  output logic [ADDR_W:0]   mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data
);

  fb_sched_state_t r_state;
  fb_sched_state_t w_nextState;

  logic              r_rdPend;
  logic [ADDR_W-1:0] r_rdAddr;
  logic              r_overrun;
  logic [DATA_W-1:0] r_dispData;
  logic              r_dispValid;
  logic              r_frontPage;
  logic              r_swapPend;
  logic              r_swapAck;
  logic              r_vblankD;
  logic [ADDR_W:0]   r_memRdAddr;
  logic [ADDR_W:0]   r_memWrAddr;
  logic [DATA_W-1:0] r_memWrData;

  logic                     w_rdBusy;
  logic                     w_rdAccept;
  logic                     w_rdWant;
  logic [ADDR_W-1:0]        w_rdSrcAddr;
  logic                     w_enterRd;
  logic                     w_enterWr;
  logic                     w_forceWr;
  logic                     w_swapDo;
  logic                     w_fifoEmpty;
  logic                     w_fifoReady;
  logic [ADDR_W+DATA_W-1:0] w_fifoHead;

  // A read already pending blocks new requests, except in RD1 where the
  // pending one completes this cycle and a new one can chain straight on.
  assign w_rdBusy    = r_rdPend && (r_state != RD1);
  assign w_rdAccept  = disp_req && !w_rdBusy;
  assign w_rdWant    = w_rdAccept || w_rdBusy;
  assign w_rdSrcAddr = w_rdAccept ? disp_addr : r_rdAddr;
  assign w_enterRd   = (w_nextState == RD0);
  assign w_enterWr   = (w_nextState == WR0);
  assign w_swapDo    = vblank && !r_vblankD && r_swapPend && w_fifoEmpty
                       && !isWriteSlot(r_state);

  fb_wr_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_wrFifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (wr_valid && w_fifoReady),
    .i_din   ({wr_addr, wr_data}),
    .i_pop   (w_enterWr),
    .o_head  (w_fifoHead),
    .o_empty (w_fifoEmpty),
    .o_ready (w_fifoReady)
  );

`ifdef FB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] C_STARVE = SW'(STARVE_MAX);
  logic [SW-1:0] r_starveCnt;

  assign w_forceWr = (r_starveCnt >= C_STARVE) && !w_fifoEmpty;

  // Count read slots granted while writes wait; any write or empty FIFO clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starveCnt <= '0;
    end else if (w_fifoEmpty || w_enterWr) begin
      r_starveCnt <= '0;
    end else if (w_enterRd && (r_starveCnt != C_STARVE)) begin
      r_starveCnt <= r_starveCnt + SW'(1);
    end
  end
`else
  assign w_forceWr = 1'b0;
`endif

  // Slot state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  // Slot selection at each slot boundary: reads first, then queued writes.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      RD0: w_nextState = RD1;
      WR0: w_nextState = WR1;
      default: begin
        if (w_rdWant && !w_forceWr) w_nextState = RD0;
        else if (!w_fifoEmpty)      w_nextState = WR0;
        else                        w_nextState = IDLE;
      end
    endcase
  end

  // Display read tracking, address latching and returned data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdPend    <= 1'b0;
      r_rdAddr    <= '0;
      r_overrun   <= 1'b0;
      r_dispData  <= '0;
      r_dispValid <= 1'b0;
      r_memRdAddr <= '0;
    end else begin
      if (w_rdAccept) begin
        r_rdPend <= 1'b1;
        r_rdAddr <= disp_addr;
      end else if (r_state == RD1) begin
        r_rdPend <= 1'b0;
      end
      if (disp_req && w_rdBusy) r_overrun <= 1'b1;
      if (w_enterRd) r_memRdAddr <= {r_frontPage, w_rdSrcAddr};
      r_dispValid <= (r_state == RD1);
      if (r_state == RD1) r_dispData <= mem_rd_data;
    end
  end

  // Write slot address/data captured from the FIFO head as it is popped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_memWrAddr <= '0;
      r_memWrData <= '0;
    end else if (w_enterWr) begin
      r_memWrAddr <= {~r_frontPage, w_fifoHead[ADDR_W+DATA_W-1 -: ADDR_W]};
      r_memWrData <= w_fifoHead[DATA_W-1:0];
    end
  end

  // Page flip: only on a vblank rising edge with no write in flight or queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frontPage <= 1'b0;
      r_swapPend  <= 1'b0;
      r_swapAck   <= 1'b0;
      r_vblankD   <= 1'b0;
    end else begin
      r_vblankD <= vblank;
      r_swapAck <= w_swapDo;
      if (w_swapDo) begin
        r_frontPage <= ~r_frontPage;
        r_swapPend  <= 1'b0;
      end else if (swap_req) begin
        r_swapPend  <= 1'b1;
      end
    end
  end

  assign disp_data    = r_dispData;
  assign disp_valid   = r_dispValid;
  assign disp_overrun = r_overrun;
  assign wr_ready     = w_fifoReady;
  assign swap_ack     = r_swapAck;
  assign front_page   = r_frontPage;
  assign mem_rd_addr  = r_memRdAddr;
  assign mem_wr_en    = isWriteSlot(r_state);
  assign mem_wr_addr  = r_memWrAddr;
  assign mem_wr_data  = r_memWrData;

endmodule

// File: tb/tb_fb_scheduler.sv
// tb_fb_scheduler: directed scoreboard bench for fb_scheduler.
// Reads and writes are predicted when driven and checked when the DUT emits them.
module tb_fb_scheduler;
  import fb_sched_pkg::*;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [ADDR_W:0]   addr;
    logic [DATA_W-1:0] data;
  } wrExp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              dispReq = 1'b0;
  logic [ADDR_W-1:0] dispAddr = '0;
  logic [DATA_W-1:0] dispData;
  logic              dispValid;
  logic              dispOverrun;
  logic              wrValid = 1'b0;
  logic              wrReady;
  logic [ADDR_W-1:0] wrAddr = '0;
  logic [DATA_W-1:0] wrData = '0;
  logic              swapReq = 1'b0;
  logic              swapAck;
  logic              vblank = 1'b0;
  logic              frontPage;
  logic [ADDR_W:0]   memRdAddr;
  logic [DATA_W-1:0] memRdData;
  logic              memWrEn;
  logic [ADDR_W:0]   memWrAddr;
  logic [DATA_W-1:0] memWrData;

  logic [DATA_W-1:0] rdQ[$];
  wrExp_t            wrQ[$];
  int                testsRun = 0;
  int                testsFailed = 0;
  int                wrSlots = 0;
  int                wrPhase = 0;
  int                ackCount = 0;
  logic              rdCheckOff = 1'b0;
  logic              modelFront = 1'b0;

  always #5 clk = ~clk;

  // SRAM read model: one distinctive word at 0x00010, otherwise a tag plus the address.
  function automatic logic [DATA_W-1:0] memModel(input logic [ADDR_W:0] a);
    if (a == 20'h00010) return 32'hDEADBEEF;
    return {12'hA5C, a};
  endfunction

  assign memRdData = memModel(memRdAddr);

  fb_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .disp_req     (dispReq),
    .disp_addr    (dispAddr),
    .disp_data    (dispData),
    .disp_valid   (dispValid),
    .disp_overrun (dispOverrun),
    .wr_valid     (wrValid),
    .wr_ready     (wrReady),
    .wr_addr      (wrAddr),
    .wr_data      (wrData),
    .swap_req     (swapReq),
    .swap_ack     (swapAck),
    .vblank       (vblank),
    .front_page   (frontPage),
    .mem_rd_addr  (memRdAddr),
    .mem_rd_data  (memRdData),
    .mem_wr_en    (memWrEn),
    .mem_wr_addr  (memWrAddr),
    .mem_wr_data  (memWrData)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic dReq, input logic [ADDR_W-1:0] dAddr,
                               input logic wV, input logic [ADDR_W-1:0] wA,
                               input logic [DATA_W-1:0] wD, input logic sReq,
                               input logic vb);
    dispReq  = dReq;
    dispAddr = dAddr;
    wrValid  = wV;
    wrAddr   = wA;
    wrData   = wD;
    swapReq  = sReq;
    vblank   = vb;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) until every predicted read and write has come out.
  task automatic waitIdle(input string tag, input int maxCycles);
    for (int i = 0; i < maxCycles; i++) begin
      if (wrQ.size() == 0 && rdQ.size() == 0 && !memWrEn) break;
      nextCycle();
    end
    checkOutput(tag, 64'(wrQ.size() + rdQ.size()), 64'd0);
  endtask

  // Scoreboard monitor: checks returned reads and both cycles of each write slot.
  always @(negedge clk) begin
    if (rst) begin
      wrPhase = 0;
    end else begin
      if (swapAck) ackCount++;
      if (dispValid && !rdCheckOff) begin
        if (rdQ.size() == 0) checkOutput("unexpected disp_valid", 64'(dispValid), 64'd0);
        else checkOutput("disp_data", 64'(dispData), 64'(rdQ.pop_front()));
      end
      if (memWrEn) begin
        if (wrQ.size() == 0) begin
          checkOutput("unexpected mem_wr_en", 64'(memWrEn), 64'd0);
        end else begin
          checkOutput("mem_wr_addr", 64'(memWrAddr), 64'(wrQ[0].addr));
          checkOutput("mem_wr_data", 64'(memWrData), 64'(wrQ[0].data));
          wrPhase++;
          if (wrPhase == SLOT_LEN) begin
            wrQ.delete(0);
            wrPhase = 0;
            wrSlots++;
          end
        end
      end else begin
        wrPhase = 0;
      end
    end
  end

  initial begin
    int pushed;
    int snap;
    logic dReq;
    logic wV;
    logic [ADDR_W-1:0] dA;
    logic [ADDR_W-1:0] wA;
    logic [DATA_W-1:0] wD;

    // Reset state
    applyStimulus(0, '0, 0, '0, '0, 0, 0);
    rst = 1'b1;
    repeat (3) nextCycle();
    rst = 1'b0;
    nextCycle();
    checkOutput("reset disp_valid", 64'(dispValid), 64'd0);
    checkOutput("reset swap_ack", 64'(swapAck), 64'd0);
    checkOutput("reset mem_wr_en", 64'(memWrEn), 64'd0);
    checkOutput("reset front_page", 64'(frontPage), 64'd0);
    checkOutput("reset wr_ready", 64'(wrReady), 64'd1);
    checkOutput("reset disp_overrun", 64'(dispOverrun), 64'd0);
    checkOutput("reset mem_rd_addr", 64'(memRdAddr), 64'd0);
    checkOutput("reset mem_wr_addr", 64'(memWrAddr), 64'd0);
    checkOutput("reset mem_wr_data", 64'(memWrData), 64'd0);

    // Single read: address out in RD0, data valid three cycles after request
    applyStimulus(1, 19'h00010, 0, '0, '0, 0, 0);
    rdQ.push_back(memModel({modelFront, 19'h00010}));
    nextCycle();
    applyStimulus(0, '0, 0, '0, '0, 0, 0);
    checkOutput("single read mem_rd_addr", 64'(memRdAddr), 64'h00010);
    nextCycle();
    checkOutput("single read early valid", 64'(dispValid), 64'd0);
    nextCycle();
    checkOutput("single read valid T+3", 64'(dispValid), 64'd1);
    checkOutput("single read data", 64'(dispData), 64'hDEADBEEF);
    nextCycle();

    // Read stream every 2 cycles while filling the FIFO: reads always win
    pushed = 0;
    snap = wrSlots;
    for (int c = 0; c < 30; c++) begin
      dReq = (c % 2 == 0);
      dA   = 19'h00100 + 19'(c);
      wV   = (pushed < 8) && (c >= 1);
      wA   = 19'h00200 + 19'(pushed);
      wD   = 32'hC0DE0000 + 32'(pushed);
      applyStimulus(dReq, dA, wV, wA, wD, 0, 0);
      if (dReq) rdQ.push_back(memModel({modelFront, dA}));
      if (wV && wrReady) begin
        wrQ.push_back(wrExp_t'{addr: {~modelFront, wA}, data: wD});
        pushed++;
      end
      nextCycle();
    end
    applyStimulus(0, '0, 0, '0, '0, 0, 0);
    checkOutput("fill pushed count", 64'(pushed), 64'd8);
    checkOutput("full wr_ready", 64'(wrReady), 64'd0);
    checkOutput("no write under read stream", 64'(wrSlots - snap), 64'd0);
    checkOutput("stream no overrun", 64'(dispOverrun), 64'd0);

`ifdef FB_STARVE_GUARD_EN
    // Guard build: keep reading past the starvation limit; a write must slip in
    rdCheckOff = 1'b1;
    for (int c = 0; c < 40; c++) begin
      applyStimulus((c % 2 == 0), 19'h00300 + 19'(c), 0, '0, '0, 0, 0);
      nextCycle();
    end
    applyStimulus(0, '0, 0, '0, '0, 0, 0);
    checkOutput("guard forced write", 64'(wrSlots - snap >= 1), 64'd1);
    repeat (6) nextCycle();
    rdQ.delete();
    rdCheckOff = 1'b0;
`endif

    // Drain: wr_ready back as soon as the first pop happens, writes in order
    for (int i = 0; i < 20; i++) begin
      if (memWrEn) break;
      nextCycle();
    end
    checkOutput("drain started", 64'(memWrEn), 64'd1);
    checkOutput("wr_ready after pop", 64'(wrReady), 64'd1);
    waitIdle("drain fill timeout", 60);
    checkOutput("drain slot count", 64'(wrSlots - snap), 64'd8);

    // Swap requested with queued writes: vblank rise must not flip
    pushed = 0;
    snap = ackCount;
    for (int c = 0; c < 14; c++) begin
      dReq = (c % 2 == 0) && (c < 12);
      dA   = 19'h00400 + 19'(c);
      wV   = (pushed < 3) && (c >= 1);
      wA   = 19'h00500 + 19'(pushed);
      wD   = 32'hBEEF0000 + 32'(pushed);
      applyStimulus(dReq, dA, wV, wA, wD, (c == 4), (c >= 6) && (c < 10));
      if (dReq) rdQ.push_back(memModel({modelFront, dA}));
      if (wV && wrReady) begin
        wrQ.push_back(wrExp_t'{addr: {~modelFront, wA}, data: wD});
        pushed++;
      end
      nextCycle();
    end
    applyStimulus(0, '0, 0, '0, '0, 0, 0);
    checkOutput("no swap with queued writes", 64'(ackCount - snap), 64'd0);
    checkOutput("front_page held", 64'(frontPage), 64'd0);
    waitIdle("drain swap timeout", 40);

    // Next vblank rise after drain flips the page with a single ack pulse
    applyStimulus(0, '0, 0, '0, '0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      if (swapAck) break;
    end
    checkOutput("swap_ack", 64'(swapAck), 64'd1);
    checkOutput("front_page at ack", 64'(frontPage), 64'd1);
    modelFront = 1'b1;
    nextCycle();
    checkOutput("swap_ack one pulse", 64'(swapAck), 64'd0);
    checkOutput("swap ack count", 64'(ackCount - snap), 64'd1);
    applyStimulus(0, '0, 0, '0, '0, 0, 0);

    // After the flip: writes land in page 0, reads come from page 1
    for (int c = 0; c < 2; c++) begin
      wA = 19'h00600 + 19'(c);
      wD = 32'h0DD00000 + 32'(c);
      applyStimulus(0, '0, 1, wA, wD, 0, 0);
      wrQ.push_back(wrExp_t'{addr: {~modelFront, wA}, data: wD});
      nextCycle();
    end
    applyStimulus(1, 19'h00055, 0, '0, '0, 0, 0);
    rdQ.push_back(memModel({modelFront, 19'h00055}));
    nextCycle();
    applyStimulus(0, '0, 0, '0, '0, 0, 0);
    waitIdle("post swap timeout", 30);

    // Two requests one cycle apart: overrun flagged, only the first is read
    applyStimulus(1, 19'h00077, 0, '0, '0, 0, 0);
    rdQ.push_back(memModel({modelFront, 19'h00077}));
    nextCycle();
    applyStimulus(1, 19'h00078, 0, '0, '0, 0, 0);
    nextCycle();
    applyStimulus(0, '0, 0, '0, '0, 0, 0);
    repeat (6) nextCycle();
    checkOutput("disp_overrun set", 64'(dispOverrun), 64'd1);
    checkOutput("overrun first addr only", 64'(memRdAddr), 64'({modelFront, 19'h00077}));
    checkOutput("overrun read count", 64'(rdQ.size()), 64'd0);

    // Reset during WR1 aborts the slot, flushes the FIFO and restores page 0
    for (int c = 0; c < 3; c++) begin
      wA = 19'h00700 + 19'(c);
      wD = 32'hFACE0000 + 32'(c);
      applyStimulus(0, '0, 1, wA, wD, 0, 0);
      wrQ.push_back(wrExp_t'{addr: {~modelFront, wA}, data: wD});
      nextCycle();
    end
    applyStimulus(0, '0, 0, '0, '0, 0, 0);
    checkOutput("in write slot before reset", 64'(memWrEn), 64'd1);
    rst = 1'b1;
    nextCycle();
    checkOutput("reset mid-slot mem_wr_en", 64'(memWrEn), 64'd0);
    checkOutput("reset mid-slot front_page", 64'(frontPage), 64'd0);
    checkOutput("reset mid-slot wr_ready", 64'(wrReady), 64'd1);
    checkOutput("reset mid-slot overrun", 64'(dispOverrun), 64'd0);
    rst = 1'b0;
    wrQ.delete();
    modelFront = 1'b0;
    snap = wrSlots;
    repeat (10) nextCycle();
    checkOutput("fifo flushed by reset", 64'(wrSlots - snap), 64'd0);
    checkOutput("no valid after reset", 64'(dispValid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
